// File: rtl/cbi980_pkg.sv
// ---------------------------------------------------------------------------
// cbi980_pkg
// Shared definitions for the CBI980 AXI4-Lite blocks.
//   - AXI response codes (OKAY / EXOKAY / SLVERR / DECERR)
//   - Master FSM state encoding (3-bit constants plus a typed enum over them)
//   - Default AxPROT / AxCACHE values driven by the master
// No ports: package only.
// ---------------------------------------------------------------------------
package cbi980_pkg;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Master state encoding
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_REQ  = 3'd1;
   localparam logic [2:0] ST_WR_RESP = 3'd2;
   localparam logic [2:0] ST_RD_REQ  = 3'd3;
   localparam logic [2:0] ST_RD_DATA = 3'd4;
   localparam logic [2:0] ST_RSP     = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      WR_REQ  = ST_WR_REQ,
      WR_RESP = ST_WR_RESP,
      RD_REQ  = ST_RD_REQ,
      RD_DATA = ST_RD_DATA,
      RSP     = ST_RSP
   } master_state_e;

   // Unprivileged, secure, data access; non-bufferable, non-cacheable
   localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0000;

endpackage

// File: rtl/cbi980_axil_master.sv
// ---------------------------------------------------------------------------
// cbi980_axil_master
// AXI4-Lite manager: turns one command at a time into a single AXI4-Lite
// read or write and hands back one response. No pipelining; exactly one
// transaction in flight.
//
// Ports
//   aclk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready            command handshake
//   cmd_write/addr/wdata/wstrb command payload (wdata/wstrb unused on reads)
//   rsp_valid/ready            response handshake
//   rsp_write/rdata/resp       response payload (rdata is 0 for writes)
//   busy                       high whenever the FSM is not idle
//   aw*/w*/b*/ar*/r*           AXI4-Lite manager channels
// ---------------------------------------------------------------------------
module cbi980_axil_master
   import cbi980_pkg::*;
#(
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              aclk,
   input  logic              rst,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [STRB_W-1:0] cmd_wstrb,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_resp,

   output logic              busy,

   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [2:0]        awprot,
   output logic [3:0]        awcache,

   output logic [DATA_W-1:0] wdata,
   output logic [STRB_W-1:0] wstrb,
   output logic              wvalid,
   input  logic              wready,

   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,

   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   output logic [2:0]        arprot,
   output logic [3:0]        arcache,

   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready
);

   master_state_e     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              write_q, write_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;

   logic              aw_hs;
   logic              w_hs;

   assign aw_hs = awvalid_q & awready;
   assign w_hs  = wvalid_q & wready;

   // Next-state and next-output logic. Every output is a flop, so each
   // state decides here what the bus will see on the following cycle.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      write_d     = write_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               wstrb_d     = cmd_wstrb;
               write_d     = cmd_write;
               cmd_ready_d = 1'b0;
               if (cmd_write) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end

         WR_REQ: begin
            // AW and W complete independently; the done flags remember
            // which one already handshook so neither is offered twice.
            if (aw_hs) begin
               awvalid_d = 1'b0;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
            end
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end

         WR_RESP: begin
            if (bvalid && bready_q) begin
               rsp_resp_d  = bresp;
               rsp_rdata_d = '0;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end

         RD_REQ: begin
            if (arvalid_q && arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end

         RD_DATA: begin
            if (rvalid && rready_q) begin
               rsp_rdata_d = rdata;
               rsp_resp_d  = rresp;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end

         RSP: begin
            // cmd_ready rises together with the return to IDLE, i.e. the
            // cycle after the response handshake.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset returns to IDLE and drops any
   // in-flight response.
   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         write_q     <= 1'b0;
         cmd_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RESP_OKAY;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         write_q     <= write_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = (state_q != IDLE);

   assign rsp_valid = rsp_valid_q;
   assign rsp_write = write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

   assign awaddr    = addr_q;
   assign awvalid   = awvalid_q;
   assign awprot    = AXI_PROT_DEFAULT;
   assign awcache   = AXI_CACHE_DEFAULT;

   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign wvalid    = wvalid_q;

   assign bready    = bready_q;

   assign araddr    = addr_q;
   assign arvalid   = arvalid_q;
   assign arprot    = AXI_PROT_DEFAULT;
   assign arcache   = AXI_CACHE_DEFAULT;

   assign rready    = rready_q;

endmodule
